// File: rtl/inst_loader_if.sv
// Beat-input stream and instruction-memory write port used by inst_loader.
// The master side is the producer of beats and the consumer of memory writes.
interface inst_loader_if #(
  parameter int unsigned DEPTH_LOG2 = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_kind;
  logic [5:0]            in_code;
  logic [4:0]            in_rs;
  logic [4:0]            in_rt;
  logic [4:0]            in_rd;
  logic [4:0]            in_shamt;
  logic [15:0]           in_imm;
  logic [25:0]           in_target;
  logic                  in_last;
  logic                  imem_we;
  logic [DEPTH_LOG2-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_valid, in_kind, in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    output in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    input  in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_loader.sv
// Instruction loader: encodes R/I/J field beats into 32-bit words and writes them
// sequentially into instruction memory, stalling the CPU for the whole session.
module inst_loader #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  inst_loader_if.slave        bus,
  output logic                cpu_stall,
  output logic                busy,
  output logic                done,
  output logic                err_illegal,
  output logic                err_full,
  output logic [DEPTH_LOG2:0] count
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                state_q, state_d;
  logic                  closing_q, closing_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  err_ill_q, err_ill_d;
  logic                  err_full_q, err_full_d;
  logic                  we_q, we_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  legal;
  logic [31:0]           enc_word;
  logic                  accept;
  logic                  at_top;

  always_comb begin
    legal    = 1'b0;
    enc_word = '0;
    case (bus.in_kind)
      2'b00: begin
        legal = bus.in_code inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h25,
                                    6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                    6'h08};
        enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_code};
      end
      2'b01: begin
        legal = bus.in_code inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23,
                                    6'h2B, 6'h04, 6'h05};
        enc_word = {bus.in_code, bus.in_rs, bus.in_rt, bus.in_imm};
      end
      2'b10: begin
        legal    = (bus.in_code == 6'h02);
        enc_word = {bus.in_code, bus.in_target};
      end
      default: begin
        legal    = 1'b0;
        enc_word = '0;
      end
    endcase
  end

  // closing_q marks the write cycle after the final beat; no beats are taken then.
  assign bus.in_ready = (state_q == StLoad) && !closing_q;
  assign accept       = bus.in_valid && bus.in_ready;
  assign at_top       = (wr_ptr_q == {DEPTH_LOG2{1'b1}});

  always_comb begin
    state_d    = state_q;
    closing_d  = closing_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    err_ill_d  = err_ill_q;
    err_full_d = err_full_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          closing_d  = 1'b0;
          wr_ptr_d   = '0;
          count_d    = '0;
          err_ill_d  = 1'b0;
          err_full_d = 1'b0;
        end
      end
      StLoad: begin
        if (closing_q) begin
          state_d   = StDone;
          closing_d = 1'b0;
        end else if (accept) begin
          if (legal) begin
            we_d    = 1'b1;
            addr_d  = wr_ptr_q;
            wdata_d = enc_word;
            count_d = count_q + 1'b1;
            // Pointer saturates at the last word; the session ends there instead.
            if (!at_top) wr_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            err_ill_d = 1'b1;
          end
          if (bus.in_last) closing_d = 1'b1;
          if (legal && at_top) begin
            closing_d = 1'b1;
            if (!bus.in_last) err_full_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      closing_q  <= 1'b0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      err_ill_q  <= 1'b0;
      err_full_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      closing_q  <= closing_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      err_ill_q  <= err_ill_d;
      err_full_q <= err_full_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = (state_q != StIdle);
  assign cpu_stall      = busy;
  assign done           = (state_q == StDone);
  assign err_illegal    = err_ill_q;
  assign err_full       = err_full_q;
  assign count          = count_q;

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter: DEPTH_LOG2, default 10, sets the instruction-memory word-address width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clk  in  1  sole clock, all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: start  in  1  begins a load session; sampled in IDLE only.
REQ-006 Port: in_valid  in  1 / in_ready  out  1  field-beat handshake; a beat transfers on a cycle where both are high.
REQ-007 Port: in_kind  in  2  encoding: 00 = R, 01 = I, 10 = J, 11 = illegal.
REQ-008 Port: in_code  in  6  funct for R; op for I and J.
REQ-009 Ports: in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
REQ-010 Ports: in_imm  in  16 / in_target  in  26  immediate and jump target.
REQ-011 Port: in_last  in  1  marks the final beat of the session.
REQ-012 Ports: imem_we  out  1 / imem_addr  out  DEPTH_LOG2 / imem_wdata  out  32  instruction-memory write port.
REQ-013 Ports: cpu_stall, busy, done, err_illegal, err_full  out  1 each; count  out  DEPTH_LOG2+1.

Function
REQ-014 FSM states SHALL be IDLE, LOAD and DONE.
REQ-015 IDLE SHALL move to LOAD on start=1; in that transition wr_ptr and count SHALL clear to 0, and err_illegal and err_full SHALL clear.
REQ-016 in_ready SHALL be 1 only in LOAD.
REQ-017 busy and cpu_stall SHALL be 1 in LOAD and DONE, and for the write cycle that follows the final accepted beat.
REQ-018 An accepted R beat SHALL encode as {6'b000000, rs, rt, rd, shamt, funct}.
REQ-019 An accepted I beat SHALL encode as {op, rs, rt, imm}.
REQ-020 An accepted J beat SHALL encode as {op, target}.
REQ-021 Legal R funct values SHALL be 20, 21, 22, 23, 2A, 2B, 24, 25, 26, 27, 00, 02, 03, 04, 06, 07 and 08 (hex).
REQ-022 Legal I op values SHALL be 08, 09, 0A, 0B, 0C, 0D, 0E, 23, 2B, 04 and 05 (hex); the only legal J op SHALL be 02.
REQ-023 Fields not used by the selected format SHALL be ignored.
REQ-024 Write latency: a legal beat accepted in cycle N SHALL produce imem_we=1 in cycle N+1, with imem_addr = wr_ptr and the encoded word registered.
REQ-025 After each legal write, wr_ptr and count SHALL increment by 1.
REQ-026 Throughput SHALL be one beat per cycle; imem_we SHALL be 0 in every other cycle.
REQ-027 An illegal beat (in_kind=11, or a code outside its set) SHALL cause no write and no pointer change, and SHALL set err_illegal, which stays set until the next start or rst.
REQ-028 A beat with in_last=1 SHALL move LOAD to DONE after acceptance, whether that beat is legal or illegal.
REQ-029 Full: when a legal beat is written at address 2^DEPTH_LOG2-1, the FSM SHALL go to DONE; err_full SHALL be set if that beat had in_last=0.
REQ-030 wr_ptr SHALL never wrap within a session.
REQ-031 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-032 In DONE, the final write SHALL already have completed.
REQ-033 start SHALL be ignored outside IDLE.
REQ-034 A beat with in_valid=1 while in_ready=0 SHALL be neither consumed nor written.
REQ-035 A simultaneous start and in_valid in IDLE SHALL consume no beat; beats are accepted from the next cycle.

Reset
REQ-036 On rst, the FSM SHALL go to IDLE, and wr_ptr, count, imem_addr and imem_wdata SHALL be 0.
REQ-037 On rst, imem_we, in_ready, busy, cpu_stall, done, err_illegal and err_full SHALL be 0.
REQ-038 A pending write SHALL be cancelled by rst: imem_we stays 0 in the cycle after rst is sampled.
REQ-039 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-040 Scenario: start; R beat funct=20, rs=1, rt=2, rd=3 -> next cycle imem_we=1, addr=0, wdata=0x00221820.
REQ-041 Scenario: continue with I op=08, rs=0, rt=8, imm=FFFF, in_last=1 -> addr=1, wdata=0x2008FFFF; done pulses once; count=2; cpu_stall falls the cycle after done.
REQ-042 Scenario: J op=02, target=0x0000010 -> wdata=0x08000010; then R funct=01 -> no write, err_illegal=1, next legal beat lands at the unchanged address.
REQ-043 Scenario: DEPTH_LOG2=2, five legal beats without in_last -> writes to addrs 0-3, err_full=1, done after the 4th write, fifth beat not accepted (in_ready=0).
REQ-044 Scenario: in_valid toggled 1,0,1,1 -> exactly three writes at consecutive addresses, no gaps in the address sequence.
REQ-045 Scenario: rst asserted in the cycle a beat is accepted -> no imem_we follows; state IDLE; all outputs 0.
